outwr_sched: RTL and testbench
==============================

Name: outwr_sched

Overview:
- Sequences the output data memory address generation unit (load/step counter with async-free sync clear) for one MVU output job.
- Accepts quantizer output words through a valid/ready handshake and converts a 2-D job descriptor into AGU load/step pulses and data memory write enables.
- The job descriptor is base address, row length, row count and row stride.
- Sits between the MVU quantizer output and the AGU/local data memory write port. One job is in flight at a time.

Parameters:
- BDBANKA, 15, data memory bank address width; must match the AGU.
- BCNT, 16, width of the row-length and row-count fields and their internal counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle job start; sampled only in IDLE.
- abort  in  1  cancels the current job.
- cfg_base  in  BDBANKA  first word address; sampled on an accepted start.
- cfg_rowlen  in  BCNT  words per row; sampled on an accepted start.
- cfg_nrows  in  BCNT  number of rows; sampled on an accepted start.
- cfg_stride  in  BDBANKA  address distance between the first words of consecutive rows; sampled on an accepted start.
- in_valid  in  1  quantizer word available.
- in_ready  out  1  scheduler accepts a word this cycle.
- wr_en  out  1  data memory write enable, aligned with the current AGU address.
- agu_load  out  1  to AGU load.
- agu_step  out  1  to AGU step.
- agu_baseaddr  out  BDBANKA  to AGU baseaddr.
- busy  out  1  job active.
- done  out  1  one-cycle pulse when a job completes.

Behaviour:
- Reset (rst_n=0, async):
  - State is IDLE.
  - All outputs are 0: in_ready, wr_en, agu_load, agu_step, busy, done, agu_baseaddr.
  - Counters and latched config are 0.
- States: IDLE, RUN, FIN.
- IDLE, start=1 with cfg_rowlen!=0 and cfg_nrows!=0:
  - Latch the config and drive agu_load=1, agu_baseaddr=cfg_base in the same cycle (combinational from cfg_base).
  - Set rowbase<=cfg_base, col<=0, row<=0, and move to RUN.
  - The AGU address is valid on the next cycle, so there is no bubble.
- IDLE, start=1 with cfg_rowlen==0 or cfg_nrows==0: no load, no writes; go to FIN (done pulses the next cycle).
- RUN:
  - busy=1 and in_ready=1.
  - A beat is accepted when in_valid&in_ready; the beat drives wr_en=1.
  - Non-last column of a row: agu_step=1 and col++.
  - Last column (col==rowlen-1), non-last row:
    - agu_load=1 and agu_step=0.
    - agu_baseaddr=rowbase+stride, computed mod 2^BDBANKA so wrap-around is allowed.
    - rowbase updates to that value, col<=0, row++.
    - The first word of the next row is writable on the next cycle, with no bubble.
  - Last column of the last row: wr_en=1, no step, no load; go to FIN.
  - in_valid=0: no outputs toggle and the state is held.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- agu_load and agu_step are never both 1.
- wr_en=1 only on accepted beats.
- start while busy is ignored, with no effect on the running job.
- abort (RUN or FIN): next state is IDLE, no done pulse, no further wr_en. A beat presented in the abort cycle is not accepted (in_ready=0 when abort=1).
- abort and start in the same IDLE cycle: abort wins and the start is dropped.
- rst_n assertion mid-job clears everything immediately. The AGU keeps its own state; the next start reloads it.
- Total accepted beats per job equal rowlen*nrows exactly.

Decomposition:
- Shared package mvu_pkg:
  - BDBANKA and BCNT defaults.
  - State encoding constants: IDLE=2'd0, RUN=2'd1, FIN=2'd2.
  - Config descriptor field widths.
- One natural sub-module, outwr_cnt2d:
  - Column/row counter pair with last_col and last_row flags and the rowbase accumulator.
  - The FSM, handshake and AGU drive stay in outwr_sched.

Test Plan:
- Basic 2-D job: base=0x0010, rowlen=3, nrows=2, stride=0x0008, in_valid held 1.
  - Load 0x0010 at the start cycle, then 6 wr_en pulses.
  - AGU addresses 0x10, 0x11, 0x12, 0x18, 0x19, 0x1A.
  - load on beat 3, done 1 cycle after beat 6.
- Backpressure gaps: same job with in_valid toggled 1,0,0,1,…
  - Identical address sequence; no step, load or wr_en in gap cycles.
- Wrap-around: base=0x7FFE, rowlen=2, nrows=2, stride=0x0004.
  - Addresses 0x7FFE, 0x7FFF, 0x0002, 0x0003.
- Zero config: rowlen=0, nrows=5.
  - No agu_load and no wr_en; done one cycle after start; busy never 1.
- Abort and restart: abort after beat 2 of a 4x4 job.
  - IDLE next cycle, no done, no more wr_en.
  - A new start (base=0x0100) loads 0x0100 correctly.
- Async reset and ignored start:
  - start during RUN is ignored and the beat count stays 6 (basic job).
  - rst_n pulled low mid-cycle forces all outputs to 0 before the next edge.

Source files
------------

// File: rtl/mvu_pkg.sv
// Shared constants for the MVU output-write path: default widths, scheduler state
// encoding and job descriptor field widths.
package mvu_pkg;

  localparam int BDBANKA_DFLT = 15;
  localparam int BCNT_DFLT    = 16;

  localparam int CFG_BASE_W   = BDBANKA_DFLT;
  localparam int CFG_STRIDE_W = BDBANKA_DFLT;
  localparam int CFG_ROWLEN_W = BCNT_DFLT;
  localparam int CFG_NROWS_W  = BCNT_DFLT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/outwr_cnt2d.sv
// Column/row counter pair for one 2-D output job, with last-column/last-row flags
// and the row base address accumulator (advanced by stride, wrapping mod 2^AW).
module outwr_cnt2d
  import mvu_pkg::*;
#(
  parameter int AW = BDBANKA_DFLT,
  parameter int CW = BCNT_DFLT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init,
  input  logic          adv,
  input  logic [AW-1:0] base,
  input  logic [CW-1:0] rowlen,
  input  logic [CW-1:0] nrows,
  input  logic [AW-1:0] stride,
  output logic          last_col,
  output logic          last_row,
  output logic [AW-1:0] rowbase_nxt
);

  logic [CW-1:0] col_r;
  logic [CW-1:0] row_r;
  logic [CW-1:0] rowlen_r;
  logic [CW-1:0] nrows_r;
  logic [AW-1:0] rowbase_r;
  logic [AW-1:0] stride_r;

  assign last_col    = (col_r == (rowlen_r - CW'(1)));
  assign last_row    = (row_r == (nrows_r - CW'(1)));
  assign rowbase_nxt = rowbase_r + stride_r;

  // Latch the descriptor on job start, then walk columns and rows on each accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r     <= '0;
      row_r     <= '0;
      rowlen_r  <= '0;
      nrows_r   <= '0;
      rowbase_r <= '0;
      stride_r  <= '0;
    end else if (init) begin
      col_r     <= '0;
      row_r     <= '0;
      rowlen_r  <= rowlen;
      nrows_r   <= nrows;
      rowbase_r <= base;
      stride_r  <= stride;
    end else if (adv) begin
      if (last_col) begin
        col_r <= '0;
        if (!last_row) begin
          row_r     <= row_r + CW'(1);
          rowbase_r <= rowbase_nxt;
        end
      end else begin
        col_r <= col_r + CW'(1);
      end
    end
  end

endmodule

// File: rtl/outwr_sched.sv
// Output write scheduler: turns a 2-D job descriptor plus a stream of quantizer
// words into AGU load/step pulses and aligned data memory write enables.
module outwr_sched
  import mvu_pkg::*;
#(
  parameter int BDBANKA = BDBANKA_DFLT,
  parameter int BCNT    = BCNT_DFLT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [BDBANKA-1:0] cfg_base,
  input  logic [BCNT-1:0]    cfg_rowlen,
  input  logic [BCNT-1:0]    cfg_nrows,
  input  logic [BDBANKA-1:0] cfg_stride,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               wr_en,
  output logic               agu_load,
  output logic               agu_step,
  output logic [BDBANKA-1:0] agu_baseaddr,
  output logic               busy,
  output logic               done
);

  state_e             state_r;
  logic               start_ok_s;
  logic               cfg_zero_s;
  logic               init_s;
  logic               last_col_s;
  logic               last_row_s;
  logic [BDBANKA-1:0] rowbase_nxt_s;

  // Gating with rst_n keeps every output low while reset is held, even if start is high.
  assign start_ok_s = rst_n & start & ~abort;
  assign cfg_zero_s = (cfg_rowlen == BCNT'(0)) || (cfg_nrows == BCNT'(0));

  outwr_cnt2d #(
    .AW (BDBANKA),
    .CW (BCNT)
  ) u_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .init        (init_s),
    .adv         (wr_en),
    .base        (cfg_base),
    .rowlen      (cfg_rowlen),
    .nrows       (cfg_nrows),
    .stride      (cfg_stride),
    .last_col    (last_col_s),
    .last_row    (last_row_s),
    .rowbase_nxt (rowbase_nxt_s)
  );

  // Handshake and AGU drive; the load address is combinational so the AGU is ready next cycle.
  always_comb begin
    init_s       = 1'b0;
    in_ready     = 1'b0;
    wr_en        = 1'b0;
    agu_load     = 1'b0;
    agu_step     = 1'b0;
    agu_baseaddr = '0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_ok_s && !cfg_zero_s) begin
          init_s       = 1'b1;
          agu_load     = 1'b1;
          agu_baseaddr = cfg_base;
        end else begin
          init_s = 1'b0;
        end
      end
      RUN: begin
        busy     = 1'b1;
        in_ready = ~abort;
        wr_en    = in_valid & ~abort;
        if (wr_en && !last_col_s) begin
          agu_step = 1'b1;
        end else if (wr_en && !last_row_s) begin
          agu_load     = 1'b1;
          agu_baseaddr = rowbase_nxt_s;
        end else begin
          agu_step = 1'b0;
        end
      end
      FIN: begin
        done = ~abort;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

  // Job sequencing: IDLE -> RUN (or straight to FIN for an empty job) -> FIN -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            state_r <= cfg_zero_s ? FIN : RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state_r <= IDLE;
          end else if (wr_en && last_col_s && last_row_s) begin
            state_r <= FIN;
          end
        end
        FIN: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_outwr_sched.sv
// Scoreboard bench for outwr_sched: expected write addresses come from row/column
// arithmetic on the descriptor; a monitor models the AGU and checks every write.
module tb_outwr_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [14:0] cfg_base = 15'd0;
  logic [15:0] cfg_rowlen = 16'd0;
  logic [15:0] cfg_nrows = 16'd0;
  logic [14:0] cfg_stride = 15'd0;
  logic        in_valid = 1'b0;
  logic        in_ready, wr_en, agu_load, agu_step, busy, done;
  logic [14:0] agu_baseaddr;

  outwr_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_base(cfg_base), .cfg_rowlen(cfg_rowlen), .cfg_nrows(cfg_nrows),
    .cfg_stride(cfg_stride), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .agu_load(agu_load), .agu_step(agu_step),
    .agu_baseaddr(agu_baseaddr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [14:0] exp_q[$];
  logic [14:0] agu_addr = 15'd0;
  int cyc_n = 0;
  int wr_cnt = 0, done_cnt = 0, busy_seen = 0, load_cnt = 0;
  int last_wr_cyc = 0, done_cyc = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string nm);
    check(nm, {11'd0, in_ready, wr_en, agu_load, agu_step, busy, done, agu_baseaddr}, 32'd0);
  endtask

  // Reference: job writes addresses base + r*stride + c, row-major, mod 2^15.
  task automatic push_job(input logic [14:0] b, input int rl, input int nr, input logic [14:0] s);
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < rl; c++)
        exp_q.push_back(15'(int'(b) + r * int'(s) + c));
  endtask

  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  // Monitor: AGU model plus per-cycle protocol checks.
  initial forever begin
    logic [14:0] e;
    @(negedge clk);
    if (rst_n) begin
      check("load_step_excl", {31'd0, agu_load & agu_step}, 32'd0);
      if (busy && !in_valid) check("gap_quiet", {29'd0, agu_load, agu_step, wr_en}, 32'd0);
      if (wr_en) begin
        check("wr_needs_valid", {31'd0, in_valid}, 32'd1);
        check("wr_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", {17'd0, agu_addr}, {17'd0, e});
        end
        wr_cnt++;
        last_wr_cyc = cyc_n;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc_n;
      end
      if (busy) busy_seen++;
      if (agu_load) load_cnt++;
      if (agu_load) agu_addr = agu_baseaddr;
      else if (agu_step) agu_addr = agu_addr + 15'd1;
    end
  end

  // mode: 0 valid held, 1 valid pattern 1,0,0, 2 random valid, 3 held + start mid-run
  task automatic run_job(input logic [14:0] b, input int rl, input int nr,
                         input logic [14:0] s, input int mode);
    int d0, w0, l0, bs0, cyc, start_cyc, nbeats;
    nbeats = rl * nr;
    in_valid = 1'b0;
    push_job(b, rl, nr, s);
    d0 = done_cnt; w0 = wr_cnt; l0 = load_cnt; bs0 = busy_seen;
    @(posedge clk); #1;
    start = 1'b1; cfg_base = b; cfg_rowlen = 16'(rl); cfg_nrows = 16'(nr); cfg_stride = s;
    @(negedge clk);
    start_cyc = cyc_n;
    check("start_load", {31'd0, agu_load}, {31'd0, nbeats != 0});
    if (nbeats != 0) check("start_base", {17'd0, agu_baseaddr}, {17'd0, b});
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (done_cnt == d0 && cyc < 2000) begin
      case (mode)
        0: in_valid = 1'b1;
        1: in_valid = (cyc % 3 == 0);
        2: in_valid = 1'($urandom_range(0, 1));
        default: begin
          in_valid = 1'b1;
          start = (cyc == 2);
          if (cyc == 2) begin
            cfg_base = 15'h0555; cfg_rowlen = 16'd1; cfg_nrows = 16'd1;
          end
        end
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    check("job_timeout", {31'd0, cyc < 2000}, 32'd1);
    check("beat_count", 32'(wr_cnt - w0), 32'(nbeats));
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("done_once", 32'(done_cnt - d0), 32'd1);
    check("load_count", 32'(load_cnt - l0), 32'((nbeats == 0) ? 0 : nr));
    if (nbeats == 0) begin
      check("done_lat_zero", 32'(done_cyc), 32'(start_cyc + 1));
      check("busy_never", 32'(busy_seen - bs0), 32'd0);
    end else begin
      check("done_lat", 32'(done_cyc), 32'(last_wr_cyc + 1));
    end
    @(negedge clk);
    check("idle_after", {30'd0, busy, done}, 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int w0, d0, cyc;
    // Reset state, with start asserted to show it cannot leak through.
    start = 1'b1; cfg_base = 15'h0010; cfg_rowlen = 16'd3; cfg_nrows = 16'd2;
    #2;
    chk_zero("reset_outputs");
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("idle_outputs");

    run_job(15'h0010, 3, 2, 15'h0008, 0);   // basic
    run_job(15'h0010, 3, 2, 15'h0008, 1);   // backpressure gaps
    run_job(15'h7FFE, 2, 2, 15'h0004, 0);   // wrap-around
    run_job(15'h0000, 0, 5, 15'h0001, 0);   // zero rowlen
    run_job(15'h0123, 4, 0, 15'h0001, 2);   // zero nrows
    run_job(15'h0010, 3, 2, 15'h0008, 3);   // start while running is ignored

    // Abort after beat 2 of a 4x4 job.
    push_job(15'h0200, 4, 4, 15'h0010);
    w0 = wr_cnt; d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; cfg_base = 15'h0200; cfg_rowlen = 16'd4; cfg_nrows = 16'd4; cfg_stride = 15'h0010;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1;
    cyc = 0;
    while (wr_cnt - w0 < 2 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_wait", {31'd0, cyc < 100}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    check("abort_ready", {30'd0, in_ready, wr_en}, 32'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_idle", {29'd0, busy, done, wr_en}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("abort_beats", 32'(wr_cnt - w0), 32'd2);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // Abort and start together in IDLE: start dropped.
    start = 1'b1; abort = 1'b1; cfg_base = 15'h0300; cfg_rowlen = 16'd2; cfg_nrows = 16'd2;
    @(negedge clk);
    check("abort_start_load", {31'd0, agu_load}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_start_idle", {30'd0, busy, done}, 32'd0);

    run_job(15'h0100, 2, 2, 15'h0004, 0);   // restart after abort

    // Asynchronous reset in the middle of a job.
    push_job(15'h0010, 3, 2, 15'h0008);
    @(posedge clk); #1;
    start = 1'b1; cfg_base = 15'h0010; cfg_rowlen = 16'd3; cfg_nrows = 16'd2; cfg_stride = 15'h0008;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    start = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset_outputs");
    @(posedge clk); #1;
    chk_zero("reset_held_outputs");
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk_zero("post_reset_idle");

    run_job(15'h0010, 3, 2, 15'h0008, 0);   // AGU reloaded by next start

    for (int k = 0; k < 6; k++)
      run_job(15'($urandom), $urandom_range(0, 4), $urandom_range(1, 3), 15'($urandom), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
